fifo_tx_serializer: RTL
=======================

FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, FIFO word width and bits per serialized word.
REQ-002 Parameter: DIV_WIDTH, 9, width of clock_divider.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-005 en  input  1  global enable; low freezes all state, counters and outputs.
REQ-006 start  input  1  request to drain the FIFO; sampled in IDLE only.
REQ-007 clock_divider  input  DIV_WIDTH  bit period N in clk cycles; values 0 and 1 treated as 2.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_data  input  DATA_WIDTH  FIFO read data, valid on the clk edge one cycle after fifo_read.
REQ-010 fifo_read  output  1  one-cycle FIFO pop strobe.
REQ-011 tx_out  output  1  serial data, MSB first.
REQ-012 tx_valid  output  1  high while tx_out carries a data bit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when draining ends.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, SHIFT, DONE; all outputs registered.
REQ-016 IDLE: start=1 and fifo_empty=0 -> REQ; start=1 and fifo_empty=1 -> DONE with no fifo_read; start=0 -> stay.
REQ-017 REQ: fifo_read=1 for exactly one cycle -> WAIT.
REQ-018 WAIT: capture fifo_data into shift register; latch effective N from clock_divider; clear bit and period counters -> SHIFT.
REQ-019 SHIFT: tx_valid=1; tx_out=shift register MSB; each bit held exactly N clk cycles, then shift left by one.
REQ-020 After DATA_WIDTH bits, on the last cycle of the last bit: fifo_empty=0 -> REQ, else -> DONE.
REQ-021 Inter-word gap SHALL be exactly 2 clk cycles (REQ, WAIT) with tx_valid=0 and tx_out holding its last value.
REQ-022 DONE: done=1 for one cycle -> IDLE; start is ignored in DONE.
REQ-023 fifo_read SHALL never assert while fifo_empty=1 or outside REQ.
REQ-024 clock_divider changes SHALL take effect only at the next word load (WAIT).
REQ-025 en=0 SHALL hold state, counters, tx_out and tx_valid; fifo_read and done SHALL be 0 while en=0 and their pulses SHALL be emitted on the first enabled cycle instead.
REQ-026 Period counter SHALL be DIV_WIDTH bits, count 0..N-1 and wrap to 0 at each bit boundary; bit counter counts 0..DATA_WIDTH-1.
REQ-027 Per-word duration from entering REQ to the last SHIFT cycle SHALL be 2 + DATA_WIDTH*N clk cycles.

Reset
REQ-028 Reset values: state=IDLE, fifo_read=0, tx_out=0, tx_valid=0, busy=0, done=0, shift register and counters 0.
REQ-029 Reset asserted mid-word SHALL abort immediately with no done pulse; the partial word is lost and no further fifo_read is issued.
REQ-030 After reset release, the block SHALL remain in IDLE until a new start.

Verification
REQ-031 FIFO holds 0x55, N=2, start pulse -> one fifo_read, tx_out 0,1,0,1,0,1,0,1 each held 2 cycles, tx_valid high 16 cycles, done pulse, IDLE.
REQ-032 FIFO holds 0xAA,0x55,0xAA,0x55 (four words), N=3 -> 4 fifo_read pulses, 2-cycle gaps with tx_valid=0, total busy 4*(2+24)+1 cycles, single done.
REQ-033 fifo_empty=1, start=1 -> no fifo_read, done pulse next cycle, busy high for 1 cycle.
REQ-034 clock_divider=0 and =1 -> each bit held exactly 2 cycles; clock_divider changed 5->2 mid-word -> current word stays at 5, next word at 2.
REQ-035 en dropped for 7 cycles in the middle of bit 3 of 0xF0 -> tx_out and counters frozen, bit 3 stretched by 7 cycles, output otherwise identical.
REQ-036 reset pulsed during bit 4 of a 2-word transfer -> all outputs 0 immediately, no done, no further fifo_read, block idles until next start.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops words from a FIFO and shifts each one out MSB
// first, holding every bit for a programmable number of clk cycles.
module fifo_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  start,
   input  logic [DIV_WIDTH-1:0]  clock_divider,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read,
   output logic                  tx_out,
   output logic                  tx_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
   localparam logic [DIV_WIDTH-1:0] PER_ONE  = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] MIN_N    = DIV_WIDTH'(2);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DIV_WIDTH-1:0]  n_q, n_d;
   logic [DIV_WIDTH-1:0]  per_q, per_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  fifo_read_q, fifo_read_d;
   logic                  tx_out_q, tx_out_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [DIV_WIDTH-1:0]  n_eff;
   logic                  per_last;
   logic                  bit_last;

   // Dividers below 2 would give a zero or one-cycle bit; clamp to 2.
   assign n_eff    = (clock_divider < MIN_N) ? MIN_N : clock_divider;
   assign per_last = (per_q == n_q - PER_ONE);
   assign bit_last = (bit_q == LAST_BIT);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      n_d         = n_q;
      per_d       = per_q;
      bit_d       = bit_q;
      fifo_read_d = fifo_read_q;
      tx_out_d    = tx_out_q;
      tx_valid_d  = tx_valid_q;
      busy_d      = busy_q;
      done_d      = done_q;
      if (en) begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  busy_d = 1'b1;
                  if (fifo_empty) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d     = REQ;
                     fifo_read_d = 1'b1;
                  end
               end
            end
            REQ: begin
               fifo_read_d = 1'b0;
               state_d     = WAIT;
            end
            WAIT: begin
               shift_d    = fifo_data;
               n_d        = n_eff;
               per_d      = '0;
               bit_d      = '0;
               tx_out_d   = fifo_data[DATA_WIDTH-1];
               tx_valid_d = 1'b1;
               state_d    = SHIFT;
            end
            SHIFT: begin
               if (per_last) begin
                  per_d = '0;
                  if (bit_last) begin
                     tx_valid_d = 1'b0;
                     if (fifo_empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d     = REQ;
                        fifo_read_d = 1'b1;
                     end
                  end else begin
                     bit_d    = bit_q + BIT_ONE;
                     shift_d  = shift_q << 1;
                     tx_out_d = shift_d[DATA_WIDTH-1];
                  end
               end else begin
                  per_d = per_q + PER_ONE;
               end
            end
            DONE: begin
               done_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
            default: begin
               state_d     = IDLE;
               fifo_read_d = 1'b0;
               tx_valid_d  = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         n_q         <= '0;
         per_q       <= '0;
         bit_q       <= '0;
         fifo_read_q <= 1'b0;
         tx_out_q    <= 1'b0;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         n_q         <= n_d;
         per_q       <= per_d;
         bit_q       <= bit_d;
         fifo_read_q <= fifo_read_d;
         tx_out_q    <= tx_out_d;
         tx_valid_q  <= tx_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Strobes are withheld while disabled and replayed once en returns.
   assign fifo_read = fifo_read_q & en;
   assign done      = done_q & en;
   assign tx_out    = tx_out_q;
   assign tx_valid  = tx_valid_q;
   assign busy      = busy_q;

endmodule
